fp8_mul_arbiter: RTL



---
 rtl/fp8_pkg.sv | 26 ++
 rtl/fp8_mul_core.sv | 55 +++++
 rtl/fp8_mul_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fp8_pkg.sv
// Shared E3M4 field layout, constants and types for the FP8 multiplier arbiter.
package fp8_pkg;

    localparam int unsigned SIGN_BIT = 7;
    localparam int unsigned EXP_MSB  = 6;
    localparam int unsigned EXP_LSB  = 4;
    localparam int unsigned MANT_W   = 4;
    localparam int unsigned EXP_BIAS = 3;

    typedef logic [7:0] fp8_t;

    localparam fp8_t       FP8_ZERO    = 8'h00;
    localparam logic [6:0] FP8_SAT_MAG = 7'h70;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // Operand pair travelling from arbitration to the multiplier
    typedef struct packed {
        fp8_t a;
        fp8_t b;
    } fp8_pair_t;

endpackage

// File: rtl/fp8_mul_core.sv
// Combinational E3M4 multiply: truncating, saturates on overflow, flushes deep underflow to zero.
module fp8_mul_core
    import fp8_pkg::*;
(
    input  fp8_t a,
    input  fp8_t b,
    output fp8_t p
);

    localparam int unsigned EXP_W  = EXP_MSB - EXP_LSB + 1;
    localparam int unsigned SIG_W  = MANT_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int          EXP_SAT = (1 << EXP_W) - 1;
    localparam int          EXP_MIN = -int'(MANT_W);

    logic              sign;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [SIG_W-1:0]  sig_a;
    logic [SIG_W-1:0]  sig_b;
    logic [PROD_W-1:0] prod;
    logic              carry;
    logic [SIG_W-1:0]  norm_sig;
    logic [SIG_W-1:0]  sub_sig;
    int                exp_r;

    always_comb begin
        p        = FP8_ZERO;
        sub_sig  = '0;
        sign     = a[SIGN_BIT] ^ b[SIGN_BIT];
        exp_a    = a[EXP_MSB:EXP_LSB];
        exp_b    = b[EXP_MSB:EXP_LSB];
        sig_a    = {|exp_a, a[MANT_W-1:0]};
        sig_b    = {|exp_b, b[MANT_W-1:0]};
        prod     = PROD_W'(sig_a) * PROD_W'(sig_b);
        carry    = prod[PROD_W-1];
        norm_sig = carry ? prod[PROD_W-1 -: SIG_W] : prod[PROD_W-2 -: SIG_W];
        exp_r    = int'(exp_a) + int'(exp_b) - int'(EXP_BIAS) + (carry ? 1 : 0);

        if (a[SIGN_BIT-1:0] == '0 || b[SIGN_BIT-1:0] == '0) begin
            p = FP8_ZERO;
        end else if (exp_r >= EXP_SAT) begin
            p = {sign, FP8_SAT_MAG};
        end else if (exp_r < EXP_MIN) begin
            p = FP8_ZERO;
        end else if (exp_r > 0) begin
            p = {sign, EXP_W'(exp_r), norm_sig[MANT_W-1:0]};
        end else begin
            // Small results land in the exp=0 encoding, shifted to drop the hidden bit
            sub_sig = norm_sig >> (1 - exp_r);
            p = (sub_sig == '0) ? FP8_ZERO : {sign, {EXP_W{1'b0}}, sub_sig[MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/fp8_mul_arbiter.sv
// Round-robin sharing of one E3M4 multiplier between NREQ requesters, ID-tagged result port.
// FP8_ARB_OUTREG_EN adds an operand stage before the multiplier (latency 2 instead of 1).
module fp8_mul_arbiter
    import fp8_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output fp8_t              res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    slot_state_e    state_q;
    slot_state_e    state_d;
    logic [IDW-1:0] last_grant_q;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand_idx;
    logic           gnt_found;
    fp8_pair_t      gnt_pair;
    logic           accept_en;
    logic           hs;
    logic           fill;
    fp8_pair_t      mul_in;
    logic [IDW-1:0] mul_id;
    fp8_t           product;

    // Rotating priority search starting just after the last winner
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        gnt_pair  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_idx = IDW'((32'(last_grant_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found  = 1'b1;
                gnt_idx    = cand_idx;
                gnt_pair.a = req_a[{cand_idx, 3'b000} +: 8];
                gnt_pair.b = req_b[{cand_idx, 3'b000} +: 8];
            end
        end
    end

    assign hs = gnt_found && accept_en && rst_n;

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

`ifdef FP8_ARB_OUTREG_EN
    logic           op_valid_q;
    fp8_pair_t      op_pair_q;
    logic [IDW-1:0] op_id_q;
    logic           op_adv;

    assign op_adv    = op_valid_q && ((state_q == EMPTY) || res_ready);
    assign accept_en = !op_valid_q || op_adv;
    assign fill      = op_adv;
    assign mul_in    = op_pair_q;
    assign mul_id    = op_id_q;
    assign busy      = (state_q == FULL) || op_valid_q;

    // Operand stage: reloads whenever it is empty or handing its pair forward
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_valid_q <= 1'b0;
            op_pair_q  <= '0;
            op_id_q    <= '0;
        end else if (accept_en) begin
            op_valid_q <= hs;
            if (hs) begin
                op_pair_q <= gnt_pair;
                op_id_q   <= gnt_idx;
            end
        end
    end
`else
    assign accept_en = (state_q == EMPTY) || res_ready;
    assign fill      = hs;
    assign mul_in    = gnt_pair;
    assign mul_id    = gnt_idx;
    assign busy      = (state_q == FULL);
`endif

    fp8_mul_core u_mul (
        .a (mul_in.a),
        .b (mul_in.b),
        .p (product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result slot: a refill in the draining cycle keeps it FULL
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (fill) state_d = FULL;
            FULL:    if (res_ready && !fill) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_data     <= FP8_ZERO;
            res_id       <= '0;
            last_grant_q <= IDW'(NREQ - 1);
        end else begin
            if (fill) begin
                res_data <= product;
                res_id   <= mul_id;
            end
            if (hs) begin
                last_grant_q <= gnt_idx;
            end
        end
    end

    assign res_valid = (state_q == FULL);

endmodule
